avl_sram_slave: RTL and testbench
=================================

# avl_sram_slave

Avalon-MM responder that terminates the data-memory bus driven by the core's memory-access stage and backs it with an on-chip word-organised RAM. It accepts one read or write per handshake and inserts a programmable number of wait states per request to emulate slower memory. Reads return data a fixed one cycle after acceptance; writes honour byte enables. It sits on the slave side of the core's data bus, alongside other bus slaves.

## Interface
- `ADDR_BASE`, default 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of two, ≥2.
- `WAIT_CYCLES`, default 0: wait states inserted before each acceptance; range 0..15.
- `clk`  in  1  clock; all logic on the rising edge.
- `rest`  in  1  reset, asynchronous, active-high.
- `avl_address`  in  32  byte address; bits [1:0] are ignored.
- `avl_byte_en`  in  4  write byte lanes; bit i selects bits [8i+7:8i].
- `avl_read`  in  1  read request; held by the master until accepted.
- `avl_write`  in  1  write request; held by the master until accepted.
- `avl_write_data`  in  32  write data.
- `avl_wait_request`  out  1  high stalls the request currently presented.
- `avl_read_data`  out  32  read data; valid only with `avl_read_data_valid`.
- `avl_read_data_valid`  out  1  one-cycle pulse per accepted read.
- `avl_response`  out  2  2'b00 OKAY, 2'b10 SLVERR; valid with `avl_read_data_valid`.

## Operation
- Request = `avl_read | avl_write`. Accepted = request & !`avl_wait_request`.
- Wait-state counter `cnt`, 4 bits. Reset value is WAIT_CYCLES.
  - Decrements by 1 each cycle a request is present and `cnt` != 0.
  - Reloads to WAIT_CYCLES on every accepted cycle.
  - Holds when no request is present.
- `avl_wait_request` = (`cnt` != 0). It is decoded from a register only; there is no combinational path from bus inputs.
- FSM states:
  - READY (`cnt` == 0): a request is accepted this cycle.
  - STALL (`cnt` > 0): decrement while a request is present.
  - With WAIT_CYCLES = 0 the block stays in READY permanently and accepts back-to-back requests every cycle.
- Word index = (`avl_address` − ADDR_BASE) >> 2, truncated to log2(DEPTH_WORDS) bits.
- Accepted write: each lane with `avl_byte_en[i]`=1 is written at the clock edge ending the accept cycle. Lanes with `avl_byte_en[i]`=0 are untouched. No response is generated for writes.
- Accepted read: `avl_read_data`, `avl_read_data_valid`=1 and `avl_response` are registered at the next edge.
- `avl_read` and `avl_write` asserted together: the write executes, the read is ignored, and no `avl_read_data_valid` pulse is produced.
- Read of the address written in the previous cycle returns the new data; the RAM is write-first.
- RAM contents are undefined after configuration and are not cleared by reset.

## Timing
- Request first present at cycle T with `cnt`=N is accepted at cycle T+N. For reads, `avl_read_data_valid` is high at T+N+1.
- `avl_read_data_valid` is high for exactly one cycle per accepted read. Between pulses `avl_read_data` holds its last value.
- Reset values: `avl_read_data`=0, `avl_read_data_valid`=0, `avl_response`=2'b00, `cnt`=WAIT_CYCLES. So `avl_wait_request`=1 if WAIT_CYCLES>0, otherwise 0.
- Reset asserted mid-stall or mid-read drops the transaction: no valid pulse follows, and `cnt` returns to WAIT_CYCLES.
- Request withdrawn during STALL (a protocol violation): `cnt` holds. The next request resumes from the held count.

## Configuration
- `AVL_SRAM_RANGE_CHECK_EN` defined:
  - An address outside [ADDR_BASE, ADDR_BASE+4·DEPTH_WORDS) is out of range.
  - Out-of-range reads still complete with normal timing, returning `avl_read_data`=0 and `avl_response`=2'b10.
  - Out-of-range writes are accepted and discarded; the RAM is unchanged.
- Not defined:
  - No range check; the index wraps modulo DEPTH_WORDS.
  - `avl_response` is constantly 2'b00.

## Test plan
- WAIT_CYCLES=0. Write 32'hA5A5_1234 at 0x10 with byte_en 4'hF, then read 0x10 in the next cycle -> no stall; `avl_read_data_valid` one cycle after the read is accepted; data 32'hA5A5_1234; response 2'b00.
- Word preloaded 32'h1122_3344. Write 32'hFFFF_FFFF with byte_en 4'b0101, then read -> 32'h11FF_33FF.
- WAIT_CYCLES=3. Read held from cycle T -> `avl_wait_request` high for T..T+2, low at T+3; `avl_read_data_valid` at T+4. A back-to-back second read stalls again for 3 cycles.
- `AVL_SRAM_RANGE_CHECK_EN` defined, DEPTH_WORDS=1024, ADDR_BASE 0:
  - Read 0x1000 -> data 0, response 2'b10.
  - Write to 0x1000 -> RAM[0] unchanged.
  - Without the macro, the same read returns RAM[0] with response 2'b00.
- `avl_read` and `avl_write` both asserted at 0x20 -> write takes effect; no valid pulse.
- Assert `rest` in the cycle after a read is accepted -> outputs are zero asynchronously; no `avl_read_data_valid` pulse after release; `cnt` equals WAIT_CYCLES.

Source files
------------

// File: rtl/avl_sram_slave_if.sv
// Avalon-MM data-bus bundle between the core's memory-access stage and a bus slave.
interface avl_sram_slave_if;
  logic [31:0] avl_address;
  logic [3:0]  avl_byte_en;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_write_data;
  logic        avl_wait_request;
  logic [31:0] avl_read_data;
  logic        avl_read_data_valid;
  logic [1:0]  avl_response;

  modport master (
    output avl_address, avl_byte_en, avl_read, avl_write, avl_write_data,
    input  avl_wait_request, avl_read_data, avl_read_data_valid, avl_response
  );

  modport slave (
    input  avl_address, avl_byte_en, avl_read, avl_write, avl_write_data,
    output avl_wait_request, avl_read_data, avl_read_data_valid, avl_response
  );
endinterface

// File: rtl/avl_sram_slave.sv
// Avalon-MM SRAM responder, WAIT_CYCLES stalls per request, read data one cycle after accept.
// Wait request is a registered count decode; AVL_SRAM_RANGE_CHECK_EN adds out-of-range SLVERR.
module avl_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input logic              clk,
  input logic              rest,
  avl_sram_slave_if.slave  bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {READY, STALL} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] rd_data_q;
  logic        rd_vld_q;
  logic [1:0]  resp_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          req;
  logic          accept;
  logic          wr_en;
  logic          rd_en;
  logic          unused_offset_bits;

  assign offset = bus.avl_address - ADDR_BASE;
  assign idx    = offset[AW+1:2];
  assign unused_offset_bits = ^{offset[1:0], offset[31:AW+2]};

`ifdef AVL_SRAM_RANGE_CHECK_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  // Addresses below the base wrap to a huge offset, so one unsigned compare covers both ends.
  assign in_range = ({1'b0, offset} < SPAN);
`else
  assign in_range = 1'b1;
`endif

  assign req    = bus.avl_read | bus.avl_write;
  assign accept = req & (state == READY);
  assign wr_en  = accept & bus.avl_write & in_range;
  // A simultaneous write wins; the read half is dropped without a response.
  assign rd_en  = accept & bus.avl_read & ~bus.avl_write;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && bus.avl_byte_en[i]) begin
        mem[idx][8*i +: 8] <= bus.avl_write_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state     <= (WAIT_CYCLES == 0) ? READY : STALL;
      cnt       <= WAIT_INIT;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      resp_q    <= 2'b00;
    end else begin
      rd_vld_q <= 1'b0;
      unique case (state)
        READY: begin
          if (req) begin
            cnt   <= WAIT_INIT;
            state <= (WAIT_CYCLES == 0) ? READY : STALL;
            if (rd_en) begin
              rd_vld_q  <= 1'b1;
              rd_data_q <= in_range ? mem[idx] : '0;
              resp_q    <= in_range ? 2'b00 : 2'b10;
            end
          end
        end
        STALL: begin
          // A withdrawn request freezes the count; it resumes when the master returns.
          if (req) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= READY;
            end
          end
        end
      endcase
    end
  end

  assign bus.avl_wait_request    = (cnt != 4'd0);
  assign bus.avl_read_data       = rd_data_q;
  assign bus.avl_read_data_valid = rd_vld_q;
  assign bus.avl_response        = resp_q;

endmodule

// File: tb/tb_avl_sram_slave.sv
// Bench for avl_sram_slave: zero-wait table run plus three-wait stall, withdrawal and reset sequences.
module tb_avl_sram_slave;

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] edata;
    logic [1:0]  eresp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          due;
  } exp_t;

`ifdef AVL_SRAM_RANGE_CHECK_EN
  localparam logic [31:0] OOR_D    = 32'h0000_0000;
  localparam logic [1:0]  OOR_R    = 2'b10;
  localparam logic [31:0] RAM0_NEW = 32'hCAFE_F00D;
  localparam logic [31:0] W3_D     = 32'h0000_0000;
  localparam logic [1:0]  W3_R     = 2'b10;
`else
  localparam logic [31:0] OOR_D    = 32'hCAFE_F00D;
  localparam logic [1:0]  OOR_R    = 2'b00;
  localparam logic [31:0] RAM0_NEW = 32'h5555_5555;
  localparam logic [31:0] W3_D     = 32'h0000_BEEF;
  localparam logic [1:0]  W3_R     = 2'b00;
`endif

  logic clk = 1'b0;
  logic rest = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avl_sram_slave_if b0();
  avl_sram_slave_if b3();

  avl_sram_slave #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rest(rest), .bus(b0));
  avl_sram_slave #(.ADDR_BASE(32'h0000_2000), .DEPTH_WORDS(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rest(rest), .bus(b3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (b0.avl_read_data_valid) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d0 unexpected valid actual=1 required=0 data=%h", b0.avl_read_data);
      end else begin
        e = q0.pop_front();
        chk("d0 rdata", b0.avl_read_data, e.data);
        chk("d0 resp", 32'(b0.avl_response), 32'(e.resp));
        chk("d0 latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (b3.avl_read_data_valid) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d3 unexpected valid actual=1 required=0 data=%h", b3.avl_read_data);
      end else begin
        e = q3.pop_front();
        chk("d3 rdata", b3.avl_read_data, e.data);
        chk("d3 resp", 32'(b3.avl_response), 32'(e.resp));
        chk("d3 latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic idle0();
    b0.avl_read = 1'b0; b0.avl_write = 1'b0; b0.avl_address = '0;
    b0.avl_byte_en = '0; b0.avl_write_data = '0;
  endtask

  task automatic idle3();
    b3.avl_read = 1'b0; b3.avl_write = 1'b0; b3.avl_address = '0;
    b3.avl_byte_en = '0; b3.avl_write_data = '0;
  endtask

  task automatic op0(input vec_t v);
    b0.avl_write = v.w; b0.avl_read = v.r; b0.avl_address = v.addr;
    b0.avl_byte_en = v.be; b0.avl_write_data = v.wdata;
    @(negedge clk);
    chk("d0 wait", 32'(b0.avl_wait_request), 32'd0);
    if (v.r && !v.w) q0.push_back('{v.edata, v.eresp, cyc + 1});
    @(posedge clk); #1;
  endtask

  task automatic op3(input bit w, input bit r, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] ed, input logic [1:0] er,
                     input int nwait, input string tag);
    b3.avl_write = w; b3.avl_read = r; b3.avl_address = a;
    b3.avl_byte_en = be; b3.avl_write_data = wd;
    for (int k = 0; k <= nwait; k++) begin
      @(negedge clk);
      chk({tag, " wait"}, 32'(b3.avl_wait_request), (k < nwait) ? 32'd1 : 32'd0);
      if (k < nwait) begin
        @(posedge clk); #1;
      end
    end
    if (r && !w) q3.push_back('{ed, er, cyc + 1});
    @(posedge clk); #1;
    idle3();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    vec_t tbl[16];
    tbl[0]  = '{1'b1, 1'b0, 32'h10,   4'hF,    32'hA5A5_1234, 32'h0,         2'b00};
    tbl[1]  = '{1'b0, 1'b1, 32'h10,   4'h0,    32'h0,         32'hA5A5_1234, 2'b00};
    tbl[2]  = '{1'b1, 1'b0, 32'h14,   4'hF,    32'h1122_3344, 32'h0,         2'b00};
    tbl[3]  = '{1'b1, 1'b0, 32'h14,   4'b0101, 32'hFFFF_FFFF, 32'h0,         2'b00};
    tbl[4]  = '{1'b0, 1'b1, 32'h14,   4'h0,    32'h0,         32'h11FF_33FF, 2'b00};
    tbl[5]  = '{1'b1, 1'b0, 32'h18,   4'hF,    32'hDEAD_BEEF, 32'h0,         2'b00};
    tbl[6]  = '{1'b1, 1'b0, 32'h18,   4'b1000, 32'h1234_5678, 32'h0,         2'b00};
    tbl[7]  = '{1'b0, 1'b1, 32'h18,   4'h0,    32'h0,         32'h12AD_BEEF, 2'b00};
    tbl[8]  = '{1'b0, 1'b1, 32'h13,   4'h0,    32'h0,         32'hA5A5_1234, 2'b00};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,    4'hF,    32'hCAFE_F00D, 32'h0,         2'b00};
    tbl[10] = '{1'b0, 1'b1, 32'h1000, 4'h0,    32'h0,         OOR_D,         OOR_R};
    tbl[11] = '{1'b1, 1'b0, 32'h1000, 4'hF,    32'h5555_5555, 32'h0,         2'b00};
    tbl[12] = '{1'b0, 1'b1, 32'h0,    4'h0,    32'h0,         RAM0_NEW,      2'b00};
    tbl[13] = '{1'b1, 1'b1, 32'h20,   4'hF,    32'h0BAD_C0DE, 32'h0,         2'b00};
    tbl[14] = '{1'b0, 1'b1, 32'h20,   4'h0,    32'h0,         32'h0BAD_C0DE, 2'b00};
    tbl[15] = '{1'b0, 1'b1, 32'h14,   4'h0,    32'h0,         32'h11FF_33FF, 2'b00};

    idle0();
    idle3();
    repeat (2) @(posedge clk);
    #1;
    chk("rst d0 wait", 32'(b0.avl_wait_request), 32'd0);
    chk("rst d0 valid", 32'(b0.avl_read_data_valid), 32'd0);
    chk("rst d0 data", b0.avl_read_data, 32'd0);
    chk("rst d0 resp", 32'(b0.avl_response), 32'd0);
    chk("rst d3 wait", 32'(b3.avl_wait_request), 32'd1);
    chk("rst d3 valid", 32'(b3.avl_read_data_valid), 32'd0);
    rest = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) op0(tbl[i]);
    idle0();
    repeat (3) @(posedge clk);
    #1;
    chk("d0 data hold", b0.avl_read_data, tbl[15].edata);

    op3(1'b1, 1'b0, 32'h2000, 4'hF, 32'h0000_BEEF, 32'h0, 2'b00, 3, "s3 wr0");
    op3(1'b1, 1'b0, 32'h2008, 4'hF, 32'h600D_F00D, 32'h0, 2'b00, 3, "s3 wr2");
    op3(1'b0, 1'b1, 32'h2008, 4'h0, 32'h0, 32'h600D_F00D, 2'b00, 3, "s3 rd1");
    op3(1'b0, 1'b1, 32'h2000, 4'h0, 32'h0, 32'h0000_BEEF, 2'b00, 3, "s3 rd2");
    op3(1'b0, 1'b1, 32'h2040, 4'h0, 32'h0, W3_D, W3_R, 3, "s3 wrap");

    // Withdraw a request mid-stall: the count must freeze and resume.
    b3.avl_read = 1'b1; b3.avl_address = 32'h2000;
    @(negedge clk);
    chk("s3 wd wait", 32'(b3.avl_wait_request), 32'd1);
    @(posedge clk); #1;
    idle3();
    repeat (2) begin
      @(negedge clk);
      chk("s3 held wait", 32'(b3.avl_wait_request), 32'd1);
      @(posedge clk); #1;
    end
    op3(1'b0, 1'b1, 32'h2000, 4'h0, 32'h0, 32'h0000_BEEF, 2'b00, 2, "s3 resume");
    repeat (2) @(posedge clk);
    #1;

    // Reset in the cycle the read response is on the bus drops it.
    b3.avl_read = 1'b1; b3.avl_address = 32'h2008;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("s3 rst accept wait", 32'(b3.avl_wait_request), 32'd0);
    @(posedge clk); #1;
    chk("s3 pre-rst valid", 32'(b3.avl_read_data_valid), 32'd1);
    rest = 1'b1;
    idle3();
    #1;
    chk("s3 rst valid", 32'(b3.avl_read_data_valid), 32'd0);
    chk("s3 rst data", b3.avl_read_data, 32'd0);
    chk("s3 rst resp", 32'(b3.avl_response), 32'd0);
    chk("s3 rst wait", 32'(b3.avl_wait_request), 32'd1);
    @(posedge clk); #1;
    rest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("s3 post-rst wait", 32'(b3.avl_wait_request), 32'd1);
    op3(1'b0, 1'b1, 32'h2008, 4'h0, 32'h0, 32'h600D_F00D, 2'b00, 3, "s3 post-rst rd");

    repeat (4) @(posedge clk);
    #1;
    chk("d0 pending", 32'(q0.size()), 32'd0);
    chk("d3 pending", 32'(q3.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
